stride_layer_ctrl: RTL
======================

STRIDE_LAYER_CTRL -- requirements
Module: stride_layer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_FEATURE_SIZE, default 12, width of row counts.
REQ-002 SHALL have parameter WIDTH_CHANNEL_NUM_REG, default 10, width of channel count.
REQ-003 SHALL have parameter WIDTH_TIMEOUT, default 20, width of stall watchdog counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset. Ports: clk, input, 1, clock; rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports Cfg_Valid in 1, Cfg_Ready out 1, Cfg_Row_Num in WIDTH_FEATURE_SIZE, Cfg_Channel_Num in WIDTH_CHANNEL_NUM_REG, Cfg_En_Stride in 1; together these form the layer descriptor handshake.
REQ-006 SHALL drive the stride unit through Row_Num_Out_REG out WIDTH_FEATURE_SIZE, Channel_Out_Num_REG out WIDTH_CHANNEL_NUM_REG, EN_Stride_REG out 1, Start out 1 and Next_Reg out 1.
REQ-007 SHALL observe the stride unit through Stride_Complete in 1, Last in 1, M_Valid in 1 and M_Ready in 1.
REQ-008 SHALL report status on Busy out 1, Layer_Done out 1 (pulse), Err_Cfg out 1 (pulse), Err_Beat out 1 (sticky), Err_Timeout out 1 (sticky) and Layer_Cnt out 8 (layers completed).

Function
REQ-009 SHALL use states IDLE, SETUP, START, RUN, NEXT, all registered.
REQ-010 SHALL assert Cfg_Ready in IDLE only; descriptor is accepted when Cfg_Valid and Cfg_Ready are both high.
REQ-011 SHALL reject a descriptor if any of the following holds: Cfg_Row_Num == 0; Cfg_Channel_Num == 0; Cfg_Channel_Num[3:0] != 0; Cfg_En_Stride and Cfg_Row_Num[0]. On rejection: Err_Cfg pulses 1 cycle, state stays IDLE, config outputs are unchanged.
REQ-012 SHALL, on acceptance, register descriptor into Row_Num_Out_REG/Channel_Out_Num_REG/EN_Stride_REG and go to SETUP; these hold stable until the next acceptance.
REQ-013 SHALL remain in SETUP exactly 2 cycles (stride unit registers config and delays Start 2 cycles), then go to START.
REQ-014 SHALL assert Start high for exactly the 1 START cycle, then go to RUN.
REQ-015 SHALL compute expected output beats E = R*R*(Channel_Out_Num_REG>>4), with R = Row_Num_Out_REG>>1 if EN_Stride_REG else Row_Num_Out_REG; width 2*WIDTH_FEATURE_SIZE+WIDTH_CHANNEL_NUM_REG, no truncation; registered before RUN.
REQ-016 SHALL count output beats (M_Valid&M_Ready) in RUN in a counter of the same width, cleared on acceptance.
REQ-017 SHALL set sticky flag in_done on Stride_Complete in RUN; when EN_Stride_REG == 0, in_done is set on entry to RUN (stride FSM stays idle and never completes).
REQ-018 SHALL set sticky flag out_done on M_Valid&M_Ready&Last in RUN; at that beat, if beat count including this beat != E, Err_Beat sets.
REQ-019 SHALL go RUN -> NEXT in the cycle after in_done and out_done are both set; simultaneous Stride_Complete and Last beat in one cycle are both captured.
REQ-020 SHALL pulse Next_Reg and Layer_Done in the 1 NEXT cycle, increment Layer_Cnt (wraps 255 -> 0), then go to IDLE.
REQ-021 SHALL run a watchdog in RUN: cleared on entry and on any beat or Stride_Complete, otherwise +1 per cycle; on reaching all-ones, Err_Timeout sets and state goes to NEXT with Next_Reg pulsed (flush), with Layer_Done low and Layer_Cnt unchanged.
REQ-022 SHALL drive Busy high in every state except IDLE.
REQ-023 SHALL ignore Stride_Complete, Last and output beats outside RUN.

Reset
REQ-024 SHALL, while rst is high, force state IDLE; Start, Next_Reg, Layer_Done, Err_Cfg, Err_Beat, Err_Timeout, Busy = 0; Layer_Cnt and all config outputs = 0; internal counters and flags = 0.
REQ-025 SHALL, on rst during any state, abandon the layer without a Next_Reg pulse; Cfg_Ready = 1 in the first cycle after rst deasserts.
REQ-026 SHALL clear Err_Beat and Err_Timeout only by rst.

Verification
REQ-027 Row=8, Ch=32, Stride=1 -> Start 3 cycles after accept; E=32; 32 beats with Last on the 32nd plus Stride_Complete -> Next_Reg 1 cycle, Layer_Cnt=1, no errors.
REQ-028 Row=4, Ch=16, Stride=0 -> E=16; Last on 16th beat -> NEXT without any Stride_Complete.
REQ-029 Ch=24, then Row=7 with Stride=1 -> Err_Cfg pulses twice, Start never asserts, Cfg_Ready stays 1.
REQ-030 Row=8, Ch=32, Stride=1, Last on 30th beat -> Err_Beat=1; layer still completes with Layer_Done.
REQ-031 WIDTH_TIMEOUT=4, no beats after Start -> Err_Timeout=1 after 15 idle RUN cycles, Next_Reg pulses, Layer_Cnt unchanged.
REQ-032 rst mid-RUN after 10 beats -> all outputs 0 next cycle, no Next_Reg; new descriptor accepted normally.

Source files
------------

// File: rtl/stride_layer_ctrl.sv
// Layer sequencer for the stride unit: accepts a layer descriptor, hands it
// to the stride unit, fires Start, tracks input/output completion and the
// beat count, and reports errors, a watchdog timeout and completed layers.
module stride_layer_ctrl #(
    parameter int WIDTH_FEATURE_SIZE    = 12,
    parameter int WIDTH_CHANNEL_NUM_REG = 10,
    parameter int WIDTH_TIMEOUT         = 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Cfg_Valid,
    output logic                             Cfg_Ready,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Cfg_Row_Num,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Cfg_Channel_Num,
    input  logic                             Cfg_En_Stride,
    output logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    output logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    output logic                             EN_Stride_REG,
    output logic                             Start,
    output logic                             Next_Reg,
    input  logic                             Stride_Complete,
    input  logic                             Last,
    input  logic                             M_Valid,
    input  logic                             M_Ready,
    output logic                             Busy,
    output logic                             Layer_Done,
    output logic                             Err_Cfg,
    output logic                             Err_Beat,
    output logic                             Err_Timeout,
    output logic [7:0]                       Layer_Cnt
);

    localparam int WIDTH_BEATS = 2 * WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM_REG;
    // Watchdog value one increment before all-ones: an idle cycle here completes the timeout.
    localparam logic [WIDTH_TIMEOUT-1:0] WDOG_LAST = {{(WIDTH_TIMEOUT-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, SETUP, START, RUN, NEXT} state_t;

    state_t                             r_state;
    state_t                             w_state_next;
    logic                               r_setup_cnt;
    logic [WIDTH_FEATURE_SIZE-1:0]      r_row_num;
    logic [WIDTH_CHANNEL_NUM_REG-1:0]   r_channel_num;
    logic                               r_en_stride;
    logic [WIDTH_BEATS-1:0]             r_expected;
    logic [WIDTH_BEATS-1:0]             r_beat_cnt;
    logic                               r_in_done;
    logic                               r_out_done;
    logic                               r_flush;
    logic                               r_err_cfg;
    logic                               r_err_beat;
    logic                               r_err_timeout;
    logic [WIDTH_TIMEOUT-1:0]           r_wdog;
    logic [7:0]                         r_layer_cnt;

    logic                               w_cfg_bad;
    logic                               w_accept;
    logic                               w_take;
    logic                               w_beat;
    logic                               w_sc;
    logic                               w_last_beat;
    logic                               w_both_done;
    logic                               w_timeout;
    logic [WIDTH_FEATURE_SIZE-1:0]      w_rows;
    logic [WIDTH_BEATS-1:0]             w_expected_calc;

    assign w_cfg_bad   = (Cfg_Row_Num == '0) || (Cfg_Channel_Num == '0) ||
                         (Cfg_Channel_Num[3:0] != 4'd0) || (Cfg_En_Stride && Cfg_Row_Num[0]);
    assign w_accept    = (r_state == IDLE) && Cfg_Valid;
    assign w_take      = w_accept && !w_cfg_bad;
    // Stride-unit events only count while a layer is running.
    assign w_beat      = (r_state == RUN) && M_Valid && M_Ready;
    assign w_sc        = (r_state == RUN) && Stride_Complete;
    assign w_last_beat = w_beat && Last;
    assign w_both_done = r_in_done && r_out_done;
    assign w_timeout   = (r_state == RUN) && !w_both_done && !w_beat && !w_sc && (r_wdog == WDOG_LAST);

    assign w_rows          = r_en_stride ? (r_row_num >> 1) : r_row_num;
    assign w_expected_calc = WIDTH_BEATS'(w_rows) * WIDTH_BEATS'(w_rows) *
                             WIDTH_BEATS'(r_channel_num >> 4);

    assign Row_Num_Out_REG     = r_row_num;
    assign Channel_Out_Num_REG = r_channel_num;
    assign EN_Stride_REG       = r_en_stride;
    assign Err_Cfg             = r_err_cfg;
    assign Err_Beat            = r_err_beat;
    assign Err_Timeout         = r_err_timeout;
    assign Layer_Cnt           = r_layer_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        w_state_next = r_state;
        Cfg_Ready    = 1'b0;
        Start        = 1'b0;
        Next_Reg     = 1'b0;
        Layer_Done   = 1'b0;
        Busy         = 1'b1;
        case (r_state)
            IDLE: begin
                Cfg_Ready = 1'b1;
                Busy      = 1'b0;
                if (w_take) w_state_next = SETUP;
            end
            SETUP: begin
                if (r_setup_cnt) w_state_next = START;
            end
            START: begin
                Start        = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                if (w_both_done || w_timeout) w_state_next = NEXT;
            end
            NEXT: begin
                Next_Reg     = 1'b1;
                Layer_Done   = !r_flush;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Descriptor capture; held until the next accepted descriptor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_num     <= '0;
            r_channel_num <= '0;
            r_en_stride   <= 1'b0;
        end else if (w_take) begin
            r_row_num     <= Cfg_Row_Num;
            r_channel_num <= Cfg_Channel_Num;
            r_en_stride   <= Cfg_En_Stride;
        end
    end

    // Two-cycle SETUP dwell and expected beat count, settled before RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_setup_cnt <= 1'b0;
            r_expected  <= '0;
        end else if (r_state == SETUP) begin
            r_setup_cnt <= ~r_setup_cnt;
            r_expected  <= w_expected_calc;
        end else begin
            r_setup_cnt <= 1'b0;
        end
    end

    // Beat counter, completion flags and beat-count check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_in_done  <= 1'b0;
            r_out_done <= 1'b0;
            r_err_beat <= 1'b0;
        end else if (w_take) begin
            r_beat_cnt <= '0;
            r_in_done  <= 1'b0;
            r_out_done <= 1'b0;
        end else begin
            // Without striding the stride unit never reports completion.
            if (r_state == START) r_in_done <= !r_en_stride;
            if (w_sc)             r_in_done <= 1'b1;
            if (w_beat)           r_beat_cnt <= r_beat_cnt + WIDTH_BEATS'(1);
            if (w_last_beat) begin
                r_out_done <= 1'b1;
                if ((r_beat_cnt + WIDTH_BEATS'(1)) != r_expected) r_err_beat <= 1'b1;
            end
        end
    end

    // Stall watchdog; a timeout flushes the layer through NEXT without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog        <= '0;
            r_flush       <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_take) r_flush <= 1'b0;
            if (r_state == START) begin
                r_wdog <= '0;
            end else if (r_state == RUN) begin
                if (w_beat || w_sc) r_wdog <= '0;
                else                r_wdog <= r_wdog + WIDTH_TIMEOUT'(1);
            end
            if (w_timeout) begin
                r_flush       <= 1'b1;
                r_err_timeout <= 1'b1;
            end
        end
    end

    // Rejected-descriptor pulse and completed-layer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cfg   <= 1'b0;
            r_layer_cnt <= '0;
        end else begin
            r_err_cfg <= w_accept && w_cfg_bad;
            if ((r_state == NEXT) && !r_flush) r_layer_cnt <= r_layer_cnt + 8'd1;
        end
    end

endmodule
